// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer and its status checker.
package alu_seq_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;

    localparam logic [1:0] GRP_INVALID   = 2'b11;
    localparam int         ST_ZERO_BIT   = 1;
    localparam int         ST_PARITY_BIT = 2;

endpackage

// File: rtl/alu_status_checker.sv
// Combinational cross-check of ALU status flags against the returned result.
// Only instantiated when ALU_STATUS_CHECK_EN is defined.
module alu_status_checker
    import alu_seq_pkg::*;
#(
    parameter int K = 8
) (
    input  logic [K-1:0] result_i,
    input  logic [3:0]   status_i,
    output logic         err_o
);

    logic zero_calc;
    logic parity_calc;
    logic unused_status_bits;

    assign zero_calc   = (result_i == '0);
    assign parity_calc = ^result_i;

    // One-sided: the ALU may raise extra flags, so only a missing flag is an error.
    assign err_o = (zero_calc   && !status_i[ST_ZERO_BIT]) ||
                   (parity_calc && !status_i[ST_PARITY_BIT]);

    assign unused_status_bits = ^{status_i[3], status_i[0]};

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the registered ALU: command in, wait out ALU latency, response out.
// Optional status cross-check enabled by defining ALU_STATUS_CHECK_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int M     = 8,
    parameter int K     = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [N-1:0]     i_cmd_op,
    input  logic [M-1:0]     i_cmd_a,
    input  logic [M-1:0]     i_cmd_b,
    output logic [N-1:0]     o_alu_op,
    output logic [M-1:0]     o_alu_a,
    output logic [M-1:0]     o_alu_b,
    input  logic [K-1:0]     i_alu_result,
    input  logic [3:0]       i_alu_status,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [K-1:0]     o_rsp_result,
    output logic [3:0]       o_rsp_status,
    output logic             o_rsp_err,
    output logic [CNT_W-1:0] o_txn_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    seq_state_t       state_q;
    logic [N-1:0]     alu_op_q;
    logic [M-1:0]     alu_a_q;
    logic [M-1:0]     alu_b_q;
    logic [K-1:0]     rsp_result_q;
    logic [3:0]       rsp_status_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             chk_err;

`ifdef ALU_STATUS_CHECK_EN
    alu_status_checker #(.K(K)) u_status_checker (
        .result_i (i_alu_result),
        .status_i (i_alu_status),
        .err_o    (chk_err)
    );
`else
    assign chk_err = 1'b0;
`endif

    // Saturating increments; the counters park at all-ones.
    assign txn_cnt_d = (txn_cnt_q == '1) ? txn_cnt_q : txn_cnt_q + CNT_W'(1);
    assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and clears every register.
        if (!i_reset) begin
            state_q      <= IDLE;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
            rsp_err_q    <= 1'b0;
            txn_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        alu_op_q <= i_cmd_op;
                        alu_a_q  <= i_cmd_a;
                        alu_b_q  <= i_cmd_b;
                        if (i_cmd_op[N-1 -: 2] == GRP_INVALID) begin
                            rsp_result_q <= '0;
                            rsp_status_q <= '0;
                            rsp_err_q    <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    rsp_result_q <= i_alu_result;
                    rsp_status_q <= i_alu_status;
                    rsp_err_q    <= chk_err;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        txn_cnt_q <= txn_cnt_d;
                        if (rsp_err_q) begin
                            err_cnt_q <= err_cnt_d;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready  = (state_q == IDLE);
    assign o_rsp_valid  = (state_q == RESP);
    assign o_alu_op     = alu_op_q;
    assign o_alu_a      = alu_a_q;
    assign o_alu_b      = alu_b_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_status = rsp_status_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_txn_cnt    = txn_cnt_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered ALU model and 2-bit counters.
module tb_alu_cmd_sequencer;

`ifdef ALU_STATUS_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [3:0] i_cmd_op;
    logic [7:0] i_cmd_a;
    logic [7:0] i_cmd_b;
    logic [3:0] o_alu_op;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [7:0] i_alu_result;
    logic [3:0] i_alu_status;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_result;
    logic [3:0] o_rsp_status;
    logic       o_rsp_err;
    logic [1:0] o_txn_cnt;
    logic [1:0] o_err_cnt;

    logic       ovr_en;
    logic [7:0] ovr_result;
    logic [3:0] ovr_status;

    int checks = 0;
    int errors = 0;
    int exp_err;

    alu_cmd_sequencer #(.N(4), .M(8), .K(8), .CNT_W(2)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_op     (i_cmd_op),
        .i_cmd_a      (i_cmd_a),
        .i_cmd_b      (i_cmd_b),
        .o_alu_op     (o_alu_op),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .i_alu_result (i_alu_result),
        .i_alu_status (i_alu_status),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_rsp_status (o_rsp_status),
        .o_rsp_err    (o_rsp_err),
        .o_txn_cnt    (o_txn_cnt),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Registered ALU model: add for op 0001, xor otherwise; status[1]=zero, status[2]=parity.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return (op == 4'b0001) ? a + b : a ^ b;
    endfunction

    always @(posedge i_clk) begin
        if (ovr_en) begin
            i_alu_result <= ovr_result;
            i_alu_status <= ovr_status;
        end else begin
            i_alu_result <= alu_f(o_alu_op, o_alu_a, o_alu_b);
            i_alu_status <= {1'b0, ^alu_f(o_alu_op, o_alu_a, o_alu_b),
                             (alu_f(o_alu_op, o_alu_a, o_alu_b) == 8'h00), 1'b0};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Present a command and hold it until accepted; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_a     = a;
        i_cmd_b     = b;
        while (!o_cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("cmd_ready_before_accept", o_cmd_ready, 1);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    // Latency counted in edges from the accept edge to the edge that sees o_rsp_valid.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!o_rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check(tag, lat, exp_lat);
    endtask

    task automatic handshake();
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        i_reset     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = '0;
        i_cmd_a     = '0;
        i_cmd_b     = '0;
        i_rsp_ready = 1'b0;
        ovr_en      = 1'b0;
        ovr_result  = '0;
        ovr_status  = '0;
        tick();
        tick();
        i_reset = 1'b1;

        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_alu_op", o_alu_op, 0);
        check("rst_alu_a", o_alu_a, 0);
        check("rst_alu_b", o_alu_b, 0);
        check("rst_rsp_result", o_rsp_result, 0);
        check("rst_rsp_status", o_rsp_status, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_txn_cnt", o_txn_cnt, 0);
        check("rst_err_cnt", o_err_cnt, 0);

        // Add 3+4 -> 7, odd parity.
        send(4'b0001, 8'h03, 8'h04);
        check("t1_alu_op", o_alu_op, 4'b0001);
        check("t1_alu_a", o_alu_a, 8'h03);
        check("t1_alu_b", o_alu_b, 8'h04);
        wait_rsp("t1_latency", 3);
        check("t1_result", o_rsp_result, 8'h07);
        check("t1_status", o_rsp_status, 4'b0100);
        check("t1_err", o_rsp_err, 0);
        handshake();
        check("t1_valid_drop", o_rsp_valid, 0);
        check("t1_cmd_ready", o_cmd_ready, 1);
        check("t1_txn_cnt", o_txn_cnt, 1);
        check("t1_err_cnt", o_err_cnt, 0);

        // rsp_ready while IDLE must be ignored.
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check("idle_ready_txn_cnt", o_txn_cnt, 1);
        check("idle_ready_valid", o_rsp_valid, 0);

        // Unsupported group 11.
        send(4'b1100, 8'h11, 8'h00);
        wait_rsp("t2_latency", 1);
        check("t2_result", o_rsp_result, 8'h00);
        check("t2_status", o_rsp_status, 4'b0000);
        check("t2_err", o_rsp_err, 1);
        check("t2_alu_op", o_alu_op, 4'b1100);
        check("t2_alu_a", o_alu_a, 8'h11);
        handshake();
        check("t2_txn_cnt", o_txn_cnt, 2);
        check("t2_err_cnt", o_err_cnt, 1);

        // Backpressure: 5A ^ 0F = 55, even parity, nonzero.
        send(4'b0010, 8'h5A, 8'h0F);
        wait_rsp("t3_latency", 3);
        i_cmd_valid = 1'b1;
        i_cmd_op    = 4'b0001;
        i_cmd_a     = 8'h01;
        i_cmd_b     = 8'h01;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", o_rsp_valid, 1);
            check("t3_hold_result", o_rsp_result, 8'h55);
            check("t3_hold_status", o_rsp_status, 4'b0000);
            check("t3_hold_cmd_ready", o_cmd_ready, 0);
            check("t3_hold_alu_a", o_alu_a, 8'h5A);
            tick();
        end
        i_cmd_valid = 1'b0;
        handshake();
        check("t3_valid_drop", o_rsp_valid, 0);
        check("t3_cmd_ready", o_cmd_ready, 1);
        check("t3_txn_cnt", o_txn_cnt, 3);
        check("t3_alu_a_unchanged", o_alu_a, 8'h5A);
        tick();
        check("t3_txn_cnt_once", o_txn_cnt, 3);

        // Reset while in WAIT.
        send(4'b0001, 8'h02, 8'h03);
        tick();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        check("t4_cmd_ready", o_cmd_ready, 1);
        check("t4_rsp_valid", o_rsp_valid, 0);
        check("t4_alu_op", o_alu_op, 0);
        check("t4_alu_a", o_alu_a, 0);
        check("t4_alu_b", o_alu_b, 0);
        check("t4_rsp_result", o_rsp_result, 0);
        check("t4_txn_cnt", o_txn_cnt, 0);
        check("t4_err_cnt", o_err_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_rsp", o_rsp_valid, 0);
        end

        // Status cross-check with forced ALU returns.
        ovr_en     = 1'b1;
        ovr_result = 8'h00;
        ovr_status = 4'b0000;
        send(4'b0001, 8'h00, 8'h00);
        wait_rsp("t5a_latency", 3);
        check("t5a_result", o_rsp_result, 8'h00);
        check("t5a_err", o_rsp_err, CHK);
        handshake();
        check("t5a_err_cnt", o_err_cnt, CHK);
        ovr_result = 8'h01;
        ovr_status = 4'b0110;
        send(4'b0001, 8'h00, 8'h01);
        wait_rsp("t5b_latency", 3);
        check("t5b_result", o_rsp_result, 8'h01);
        check("t5b_status", o_rsp_status, 4'b0110);
        check("t5b_err", o_rsp_err, 0);
        handshake();
        check("t5b_txn_cnt", o_txn_cnt, 2);
        ovr_en = 1'b0;

        // Saturation of both 2-bit counters.
        exp_err = CHK;
        for (int i = 0; i < 3; i++) begin
            send(4'b1111, 8'(i), 8'h00);
            wait_rsp("t6_latency", 1);
            handshake();
            exp_err = (exp_err < 3) ? exp_err + 1 : 3;
            check("t6_txn_cnt", o_txn_cnt, 3);
            check("t6_err_cnt", o_err_cnt, exp_err);
        end
        send(4'b0001, 8'h10, 8'h20);
        wait_rsp("t6_last_latency", 3);
        check("t6_last_result", o_rsp_result, 8'h30);
        handshake();
        check("t6_txn_sat", o_txn_cnt, 2'b11);
        check("t6_err_sat", o_err_cnt, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
